// File: rtl/wb_burst_responder.sv
// Wishbone B3 slave with a 64 x 32-bit memory, wait states and burst support.
// Optional retry termination is enabled by defining WB_RESP_RTY_EN.
module wb_burst_responder #(
    parameter int WAIT_STATES = 2,
    parameter int RTY_PERIOD  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [15:0] beat_cnt_o
);

    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    typedef enum logic [1:0] {T_NONE, T_ACK, T_ERR, T_RTY} term_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [5:0]  r_idx;
    logic        r_we;
    logic        r_oor;
    logic [2:0]  r_cti;
    logic [1:0]  r_bte;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic [15:0] r_beat_cnt;
    logic [31:0] r_mem [64];

    logic        w_req;
    logic        w_accept;
    logic        w_first_rty;
    logic        w_first_oor;
    logic        w_cont;
    logic        w_beat_we;
    logic        w_mem_we;
    logic [1:0]  w_beat_bte;
    logic [5:0]  w_beat_idx;
    logic [5:0]  w_next_idx;
    term_t       w_term;
    logic        w_unused;

    assign w_req       = wb_cyc_i & wb_stb_i;
    assign w_first_oor = (r_state == S_IDLE) ? (|wb_adr_i[31:8]) : r_oor;
    assign w_unused    = ^wb_adr_i[1:0];

`ifdef WB_RESP_RTY_EN
    localparam int RW = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;

    logic [RW-1:0] r_rty_cnt;
    logic          r_rty_pend;
    logic          r_rty;
    logic          w_rty_hit;

    assign w_rty_hit   = (r_rty_cnt == RW'(RTY_PERIOD - 1));
    assign w_first_rty = (r_state == S_IDLE) ? w_rty_hit : r_rty_pend;
    assign wb_rty_o    = r_rty;

    // Counts accepted bus cycles; the one that wraps the counter is retried.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_rty_cnt  <= '0;
            r_rty_pend <= 1'b0;
            r_rty      <= 1'b0;
        end else begin
            r_rty <= (w_term == T_RTY);
            if (w_accept) begin
                r_rty_cnt  <= w_rty_hit ? '0 : r_rty_cnt + 1'b1;
                r_rty_pend <= w_rty_hit;
            end
        end
    end
`else
    assign w_first_rty = 1'b0;
    assign wb_rty_o    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_term      = T_NONE;
        w_cont      = 1'b0;
        w_beat_idx  = r_idx;
        w_beat_we   = r_we;
        w_beat_bte  = r_bte;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_beat_idx = wb_adr_i[7:2];
                        w_beat_we  = wb_we_i;
                        w_beat_bte = wb_bte_i;
                        w_term     = w_first_rty ? T_RTY : (w_first_oor ? T_ERR : T_ACK);
                        w_cont     = (wb_cti_i == CTI_INCR);
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (wb_stb_i && r_wait_cnt <= 4'd1) begin
                    w_term = w_first_rty ? T_RTY : (w_first_oor ? T_ERR : T_ACK);
                    w_cont = (r_cti == CTI_INCR);
                end
            end
            S_BURST: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (wb_stb_i) begin
                    w_term = T_ACK;
                    w_cont = (wb_cti_i == CTI_INCR);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_term != T_NONE) begin
            w_state_nxt = (w_term == T_ACK && w_cont) ? S_BURST : S_DONE;
        end
    end

    // Wrapping bursts only advance the low bits of the word index.
    always_comb begin
        case (w_beat_bte)
            2'b00:   w_next_idx = w_beat_idx + 6'd1;
            2'b01:   w_next_idx = {w_beat_idx[5:2], w_beat_idx[1:0] + 2'd1};
            2'b10:   w_next_idx = {w_beat_idx[5:3], w_beat_idx[2:0] + 3'd1};
            default: w_next_idx = {w_beat_idx[5:4], w_beat_idx[3:0] + 4'd1};
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wait_cnt <= 4'd0;
            r_idx      <= 6'd0;
            r_we       <= 1'b0;
            r_oor      <= 1'b0;
            r_cti      <= 3'd0;
            r_bte      <= 2'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'd0;
            r_beat_cnt <= 16'd0;
        end else begin
            r_ack <= (w_term == T_ACK);
            r_err <= (w_term == T_ERR);
            if (w_accept) begin
                r_idx      <= wb_adr_i[7:2];
                r_we       <= wb_we_i;
                r_oor      <= |wb_adr_i[31:8];
                r_cti      <= wb_cti_i;
                r_bte      <= wb_bte_i;
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_term == T_ACK) begin
                r_idx <= w_next_idx;
                if (!w_beat_we) r_dat <= r_mem[w_beat_idx];
                if (r_beat_cnt != 16'hFFFF) r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

    // Reset gates the write so a beat in flight cannot land while reset is held.
    assign w_mem_we = wb_rst_n_i && (w_term == T_ACK) && w_beat_we;

    // NOTE: the memory array has no reset; its contents survive reset by design.
    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) r_mem[w_beat_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb_dat_o   = r_dat;
    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign beat_cnt_o = r_beat_cnt;

endmodule
